// File: rtl/serial_atx_pkg.sv
// rtl/serial_atx_pkg.sv - shared serial definitions for the RX and TX paths
package serial_atx_pkg;

    localparam int DATA_W = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } serial_state_t;

    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input int mode);
        logic p;
        p = ^data;
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/serial_atx.sv
// rtl/serial_atx.sv - RS-232 transmitter, 8 data bits LSB first, one-entry holding register
module serial_atx
    import serial_atx_pkg::*;
#(
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud8tick,
    input  logic [DATA_W-1:0] txd_data,
    input  logic              txd_start,
    output logic              txd_ready,
    output logic              txd,
    output logic              txd_busy,
    output logic              txd_done
);

    // Out-of-range parameter values collapse to no parity / one stop bit.
    localparam bit PAR_EN   = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
    localparam bit STOP2_EN = (STOP_BITS == 2);

    serial_state_t     state;
    logic [2:0]        phase;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;

    logic bit_end;
    logic frame_end;
    logic load;

    assign bit_end   = baud8tick && (phase == 3'd7);
    assign frame_end = bit_end && (((state == ST_STOP1) && !STOP2_EN) || (state == ST_STOP2));
    // A new frame starts from IDLE on any tick, or straight off the last stop bit.
    assign load      = baud8tick && hold_valid && ((state == ST_IDLE) || frame_end);

    assign txd_ready = ~hold_valid;
    assign txd_busy  = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase      <= 3'd0;
            bit_idx    <= 3'd0;
            shift      <= '0;
            par_bit    <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            txd        <= 1'b1;
            txd_done   <= 1'b0;
        end else begin
            txd_done <= frame_end;

            // load needs hold_valid=1 and a write needs hold_valid=0, so these never collide.
            if (txd_start && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= txd_data;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            if (baud8tick && (state != ST_IDLE)) begin
                phase <= phase + 3'd1;
            end

            if (load) begin
                state   <= ST_START;
                phase   <= 3'd0;
                shift   <= hold_data;
                par_bit <= parity_bit(hold_data, PARITY);
                txd     <= 1'b0;
            end else if (bit_end) begin
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        bit_idx <= 3'd0;
                        txd     <= shift[0];
                    end
                    ST_DATA: begin
                        if (bit_idx == 3'd7) begin
                            if (PAR_EN) begin
                                state <= ST_PARITY;
                                txd   <= par_bit;
                            end else begin
                                state <= ST_STOP1;
                                txd   <= 1'b1;
                            end
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP1;
                        txd   <= 1'b1;
                    end
                    ST_STOP1: begin
                        state <= STOP2_EN ? ST_STOP2 : ST_IDLE;
                        txd   <= 1'b1;
                    end
                    ST_STOP2: begin
                        state <= ST_IDLE;
                        txd   <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_atx.sv
// tb/tb_serial_atx.sv - four-configuration bench for serial_atx against a frame-level model
module tb_serial_atx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud8tick = 1'b0;
    logic       txd_start = 1'b0;
    logic [7:0] txd_data = 8'h00;

    logic [3:0] txd_w, ready_w, busy_w, done_w;

    int checks = 0;
    int errors = 0;
    int tick_mode = 1;

    always #5 clk = ~clk;

    serial_atx #(.PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .rst(rst), .baud8tick(baud8tick),
        .txd_data(txd_data), .txd_start(txd_start), .txd_ready(ready_w[0]), .txd(txd_w[0]),
        .txd_busy(busy_w[0]), .txd_done(done_w[0]));
    serial_atx #(.PARITY(2), .STOP_BITS(1)) u1 (.clk(clk), .rst(rst), .baud8tick(baud8tick),
        .txd_data(txd_data), .txd_start(txd_start), .txd_ready(ready_w[1]), .txd(txd_w[1]),
        .txd_busy(busy_w[1]), .txd_done(done_w[1]));
    serial_atx #(.PARITY(1), .STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .baud8tick(baud8tick),
        .txd_data(txd_data), .txd_start(txd_start), .txd_ready(ready_w[2]), .txd(txd_w[2]),
        .txd_busy(busy_w[2]), .txd_done(done_w[2]));
    serial_atx #(.PARITY(3), .STOP_BITS(5)) u3 (.clk(clk), .rst(rst), .baud8tick(baud8tick),
        .txd_data(txd_data), .txd_start(txd_start), .txd_ready(ready_w[3]), .txd(txd_w[3]),
        .txd_busy(busy_w[3]), .txd_done(done_w[3]));

    function automatic int par_of(input int i);
        case (i)
            1: return 2;
            2: return 1;
            3: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int i);
        case (i)
            2: return 2;
            3: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int frame_bits_n(input int i);
        int p;
        p = par_of(i);
        return 10 + (((p == 1) || (p == 2)) ? 1 : 0) + ((stop_of(i) == 2) ? 1 : 0);
    endfunction

    // Line levels of a whole frame, one entry per bit time, padded with idle ones.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input int i);
        logic [11:0] fb;
        int p;
        p = par_of(i);
        fb = '1;
        fb[0] = 1'b0;
        fb[8:1] = d;
        if (p == 2) fb[9] = ^d;
        else if (p == 1) fb[9] = ~^d;
        return fb;
    endfunction

    task automatic chk(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %b expected %b at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0d expected %0d", name, i, act, exp);
        end
    endtask

    bit          m_hv[4];
    logic [7:0]  m_hd[4];
    bit          m_act[4];
    int          m_cnt[4];
    int          m_nb[4];
    logic [11:0] m_bits[4];
    bit          m_txd[4];
    bit          m_done[4];
    bit          m_last_tick = 1'b0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        bit acc, ld;
        started = 1'b1;
        m_last_tick = baud8tick;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_hv[i] = 1'b0; m_act[i] = 1'b0; m_txd[i] = 1'b1;
                m_done[i] = 1'b0; m_cnt[i] = 0;
            end else begin
                acc = txd_start && !m_hv[i];
                ld = 1'b0;
                m_done[i] = 1'b0;
                if (baud8tick) begin
                    if (m_act[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == m_nb[i] * 8) begin
                            m_done[i] = 1'b1;
                            if (m_hv[i]) ld = 1'b1;
                            else begin
                                m_act[i] = 1'b0;
                                m_txd[i] = 1'b1;
                            end
                        end else begin
                            m_txd[i] = m_bits[i][m_cnt[i] / 8];
                        end
                    end else if (m_hv[i]) begin
                        ld = 1'b1;
                    end
                end
                if (ld) begin
                    m_bits[i] = frame_bits(m_hd[i], i);
                    m_nb[i] = frame_bits_n(i);
                    m_cnt[i] = 0;
                    m_act[i] = 1'b1;
                    m_txd[i] = 1'b0;
                    m_hv[i] = 1'b0;
                end
                if (acc) begin
                    m_hv[i] = 1'b1;
                    m_hd[i] = txd_data;
                end
            end
        end
    end

    int len_cnt[4];
    int frame_len[4];
    logic par_samp[4];

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 4; i++) begin
                chk("txd", i, txd_w[i], m_txd[i]);
                chk("txd_ready", i, ready_w[i], !m_hv[i]);
                chk("txd_busy", i, busy_w[i], m_act[i]);
                chk("txd_done", i, done_w[i], m_done[i]);
                // Independent tick counter driven only by DUT outputs, for literal length checks.
                if (rst) begin
                    len_cnt[i] = 0;
                end else if (done_w[i]) begin
                    frame_len[i] = len_cnt[i];
                    len_cnt[i] = (m_last_tick && busy_w[i]) ? 1 : 0;
                end else if (m_last_tick && busy_w[i]) begin
                    len_cnt[i]++;
                    if (len_cnt[i] == 77) par_samp[i] = txd_w[i];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (tick_mode)
                0: baud8tick = 1'b0;
                1: baud8tick = ~baud8tick;
                default: baud8tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    task automatic do_write(input logic [7:0] d);
        @(negedge clk);
        txd_data = d;
        txd_start = 1'b1;
        @(negedge clk);
        txd_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (((busy_w != 4'h0) || (ready_w != 4'hF)) && (n < 4000)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL wait_idle timeout busy=%b ready=%b", busy_w, ready_w);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_txd", 0, txd_w[0], 1'b1);
        chk("reset_ready", 0, ready_w[0], 1'b1);
        chk("reset_busy", 0, busy_w[0], 1'b0);

        do_write(8'h55);
        wait_idle();
        chk_int("frame_len", 0, frame_len[0], 80);
        chk_int("frame_len", 1, frame_len[1], 88);
        chk_int("frame_len", 2, frame_len[2], 96);
        chk_int("frame_len", 3, frame_len[3], 80);

        do_write(8'hA5);
        repeat (10) @(negedge clk);
        do_write(8'h3C);
        chk("queued_ready", 0, ready_w[0], 1'b0);
        wait_idle();

        do_write(8'h11);
        repeat (6) @(negedge clk);
        do_write(8'h12);
        repeat (6) @(negedge clk);
        do_write(8'hFF);
        wait_idle();

        do_write(8'h07);
        wait_idle();
        chk("even_parity_07", 1, par_samp[1], 1'b1);
        chk("odd_parity_07", 2, par_samp[2], 1'b0);

        do_write(8'hC3);
        repeat (75) @(negedge clk);
        chk("mid_frame_busy", 0, busy_w[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_txd", 0, txd_w[0], 1'b1);
        chk("rst_mid_ready", 0, ready_w[0], 1'b1);
        chk("rst_mid_busy", 0, busy_w[0], 1'b0);
        chk("rst_mid_done", 0, done_w[0], 1'b0);
        rst = 1'b0;
        do_write(8'h81);
        wait_idle();

        do_write(8'h5A);
        repeat (30) @(negedge clk);
        tick_mode = 0;
        repeat (50) @(negedge clk);
        tick_mode = 1;
        wait_idle();

        tick_mode = 2;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            txd_start = ($urandom_range(0, 5) == 0);
            txd_data = 8'($urandom);
            rst = ($urandom_range(0, 1999) == 0);
        end
        txd_start = 1'b0;
        rst = 1'b0;
        tick_mode = 1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_atx.md
Name: serial_atx

Overview:
Asynchronous RS-232 transmitter, 8 data bits, LSB first, idle-high line. It is the transmit companion to the serial RX path and shares the same baud8tick strobe, which pulses once per 1/8 bit time. It accepts bytes through a one-entry holding register, so the CPU-side UART logic can queue the next byte while the current frame shifts out. Back-to-back frames go out with no idle gap.

Parameters:
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even (3 is treated as none).
STOP_BITS, 1, number of stop bits: 1 or 2 (any other value is treated as 1).

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
baud8tick  input  1  single-cycle strobe at 8x the baud rate; the FSM advances only on cycles where this is high.
txd_data  input  8  byte to send; sampled only on an accepted write.
txd_start  input  1  write request; accepted only when txd_ready=1 in the same cycle.
txd_ready  output  1  holding register empty; a write is possible this cycle.
txd  output  1  serial line out; registered, idle = 1.
txd_busy  output  1  frame in progress (state != IDLE).
txd_done  output  1  one-cycle pulse at the end of the final stop bit of each frame.

Behaviour:
- Reset (synchronous, any time, including mid-frame): txd=1, txd_ready=1, txd_busy=0, txd_done=0, state=IDLE, phase=0, holding register invalid. A partly sent frame is abandoned and the line returns high on the next edge.
- Holding register (hold_valid, hold_data):
  - Accepted write (txd_start && txd_ready): load hold_data and set hold_valid; txd_ready=0 from the next cycle.
  - txd_start while txd_ready=0 is ignored. The held byte is never overwritten.
- Phase counter: 3-bit, increments on each baud8tick while state != IDLE and wraps 7 -> 0. Each bit lasts exactly 8 baud8ticks. "bit_end" = baud8tick && phase==7.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: on baud8tick with hold_valid=1, go to START with phase=0. In the same edge, copy hold_data to the shift register, clear hold_valid (txd_ready=1 next cycle), and set txd=0.
  - START -> DATA on bit_end; bit index = 0 and txd = shift[0].
  - DATA: on bit_end, shift right and increment the bit index. After bit 7, go to PARITY if PARITY is 1 or 2, otherwise to STOP1.
  - PARITY: txd = ^byte for even, ~^byte for odd. On bit_end go to STOP1.
  - STOP1: txd=1. On bit_end, go to STOP2 if STOP_BITS=2; otherwise the frame ends.
  - STOP2: txd=1. On bit_end the frame ends.
  - Frame end: pulse txd_done for one cycle. If hold_valid=1, go directly to START (txd=0 on the same edge, reload the shift register, clear hold_valid). Otherwise go to IDLE.
- Frame length = 8*(10 + P + (STOP_BITS-1)) baud8ticks, where P = 1 if parity is enabled.
- Latency: write at cycle N sets hold_valid at N+1. The start bit begins on the first baud8tick at or after N+1 while in IDLE, or at the end of the current frame if one is in progress.
- Simultaneous write and shift-register load: not possible, because txd_ready=0 on the load cycle. The write is ignored and txd_ready rises on the next cycle.
- No baud8tick: all state, phase and txd hold their values. txd_ready still responds to writes.
- txd comes directly from a flop, so the line never glitches between bits.

Decomposition:
- Shared serial definitions include/package: state encodings (IDLE..STOP2), parity mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2) and data width 8. These are shared with the RX block.
- No sub-module. The FSM, phase counter, shift register and inline parity stay flat; the baud generator stays external.

Test Plan:
- PARITY=0, STOP_BITS=1, write 0x55 when idle -> txd shows 0,1,0,1,0,1,0,1,0,1, each held for 8 ticks. txd_done pulses exactly 80 ticks after the start bit. txd returns to 1 and txd_busy=0.
- Write 0xA5, then 0x3C while the first frame is busy -> the 0x3C start bit begins on the edge that ends the 0xA5 stop bit, with zero idle ticks between frames. txd_ready is 0 from the second write until the 0x3C load.
- PARITY=2 with 0x07 -> parity bit 1; PARITY=1 with 0x07 -> parity bit 0. STOP_BITS=2 -> 16 high ticks before txd_done, and frame length 96 ticks.
- With txd_ready=0, pulse txd_start with 0xFF -> ignored. The queued byte (e.g. 0x12) is sent unchanged.
- Assert rst during DATA bit 3 -> next cycle txd=1, txd_ready=1, txd_busy=0, and no txd_done pulse. A write of 0x81 after reset sends a clean frame.
- Hold baud8tick low for 50 cycles mid-bit -> txd and phase are frozen. Bit widths resume correctly when ticks restart.
